// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request handshake and
// feeds the IF/ID register, with bubbles, stall holding and delayed redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ena_if_id,
  output logic [31:0] pc8_if,
  output logic [31:0] instr_if,
  output logic        if_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_buf;
  logic        pend_valid;
  logic [31:0] pend_pc;

  logic        deliver_req;
  logic        deliver_hold;
  logic        delivered;
  logic        redir_taken;
  logic [31:0] redir_target;
  logic [31:0] next_pc;

  assign ena_if_id    = ~stall_id;
  assign deliver_req  = (state == REQ) && imem_ready && !stall_id;
  assign deliver_hold = (state == HOLD) && !stall_id;
  assign delivered    = deliver_req || deliver_hold;

  // A redirect only counts when ID is actually advancing this cycle.
  assign redir_taken  = redirect_valid && !stall_id;
  assign redir_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    next_pc = fetch_pc + 32'd4;
    if (redir_taken)
      next_pc = redir_target;
    else if (pend_valid)
      next_pc = pend_pc;
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign if_valid  = delivered;
  assign pc8_if    = delivered ? (fetch_pc + 32'd8) : 32'd0;

  always_comb begin
    instr_if = NOP_WORD;
    if (deliver_req)
      instr_if = imem_rdata;
    else if (deliver_hold)
      instr_if = hold_buf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      hold_buf   <= NOP_WORD;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready && stall_id) begin
            hold_buf <= imem_rdata;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!stall_id)
            state <= REQ;
        end
        default: state <= IDLE;
      endcase

      // The word delivered alongside or after a redirect is the delay slot;
      // the target is remembered until that delivery happens.
      if (delivered) begin
        fetch_pc   <= next_pc;
        pend_valid <= 1'b0;
      end else if (redir_taken) begin
        pend_valid <= 1'b1;
        pend_pc    <= redir_target;
      end
    end
  end

endmodule
